// File: rtl/cv_seq_gen.sv
// Sequence generator: plays a programmable 16-entry nibble table as DAT_O/STB_O,
// paced by the 1 kHz clock-enable, in single-shot or looped mode.
module cv_seq_gen #(
    parameter int STEP_TICKS = 250,
    parameter int CNT_WDT    = 16
) (
    input  logic       CLK_48,
    input  logic       SYS_NRST,
    input  logic       CE,
    input  logic       START,
    input  logic       STOP,
    input  logic       LOOP,
    input  logic [3:0] LEN,
    input  logic       WR_EN,
    input  logic [3:0] WR_ADDR,
    input  logic [3:0] WR_DAT,
    output logic [3:0] DAT_O,
    output logic       STB_O,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] IDX_O
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} state_t;

    localparam logic [CNT_WDT-1:0] RELOAD = CNT_WDT'(STEP_TICKS - 1);

    logic [1:0]         rst_sync;
    logic               rst_n;
    state_t             state;
    logic [15:0][3:0]   tbl;
    logic [CNT_WDT-1:0] cnt;
    logic [3:0]         len_l;
    logic               loop_l;

    // Async assert, sync release; everything below resets from the synchronised copy.
    always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
        if (!SYS_NRST) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge CLK_48 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            tbl    <= '0;
            cnt    <= '0;
            len_l  <= '0;
            loop_l <= 1'b0;
            DAT_O  <= '0;
            STB_O  <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            IDX_O  <= '0;
        end else begin
            // Writes only land in IDLE, so the table is frozen for the whole run.
            if (WR_EN && state == S_IDLE) tbl[WR_ADDR] <= WR_DAT;

            if (STOP) begin
                state <= S_IDLE;
                STB_O <= 1'b0;
                DONE  <= 1'b0;
                BUSY  <= 1'b0;
                IDX_O <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        STB_O <= 1'b0;
                        DONE  <= 1'b0;
                        if (START) begin
                            state  <= S_WAIT;
                            len_l  <= LEN;
                            loop_l <= LOOP;
                            IDX_O  <= '0;
                            cnt    <= RELOAD;
                            BUSY   <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (CE) begin
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end else begin
                                state <= S_EMIT;
                                DAT_O <= tbl[IDX_O];
                                STB_O <= 1'b1;
                            end
                        end
                    end
                    S_EMIT: begin
                        STB_O <= 1'b0;
                        cnt   <= RELOAD;
                        if (IDX_O != len_l) begin
                            IDX_O <= IDX_O + 4'd1;
                            state <= S_WAIT;
                        end else if (loop_l) begin
                            IDX_O <= '0;
                            state <= S_WAIT;
                        end else begin
                            IDX_O <= '0;
                            state <= S_DONE;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                        end
                    end
                    default: begin
                        DONE  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cv_seq_gen.sv
// Directed bench for cv_seq_gen: vector table of single-shot runs plus hand-written
// sequences for reset, looping, STOP and writes/START while busy.
`timescale 1ns/1ps
module tb_cv_seq_gen;

    logic       CLK_48 = 1'b0;
    logic       SYS_NRST = 1'b0;
    logic       CE = 1'b0, START = 1'b0, STOP = 1'b0, LOOP = 1'b0, WR_EN = 1'b0;
    logic [3:0] LEN = '0, WR_ADDR = '0, WR_DAT = '0;
    logic [3:0] DAT_O, IDX_O;
    logic       STB_O, BUSY, DONE;

    int checks = 0, failures = 0;
    int cyc = 0;
    int done_n = 0, done_cyc = 0, consec = 0;
    bit prev_stb = 1'b0;
    logic [3:0] q[$];
    int         qc[$];

    cv_seq_gen #(.STEP_TICKS(2), .CNT_WDT(16)) dut (
        .CLK_48(CLK_48), .SYS_NRST(SYS_NRST), .CE(CE), .START(START), .STOP(STOP),
        .LOOP(LOOP), .LEN(LEN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DAT(WR_DAT),
        .DAT_O(DAT_O), .STB_O(STB_O), .BUSY(BUSY), .DONE(DONE), .IDX_O(IDX_O)
    );

    always #5 CLK_48 = ~CLK_48;

    // CE high one cycle in four
    always begin
        @(posedge CLK_48); #1;
        cyc++;
        CE = (cyc % 4 == 0);
    end

    always @(negedge CLK_48) begin
        if (STB_O) begin
            q.push_back(DAT_O);
            qc.push_back(cyc);
            if (prev_stb) consec++;
        end
        if (DONE) begin
            done_n++;
            done_cyc = cyc;
        end
        prev_stb = STB_O;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK_48); #1;
        end
    endtask

    task automatic write_tab(input logic [63:0] tab);
        for (int a = 0; a < 16; a++) begin
            WR_EN = 1'b1; WR_ADDR = 4'(a); WR_DAT = tab[a*4 +: 4];
            tick();
        end
        WR_EN = 1'b0;
    endtask

    // mode 0: plain; 1: write addr1=9 after first strobe; 2: START with LEN=15/LOOP=1 after first strobe
    task automatic play(input string tag, input logic [3:0] len, input int n,
                        input logic [63:0] exp, input int mode);
        bit acted = 1'b0;
        int d;
        q.delete(); qc.delete(); done_n = 0;
        LEN = len; LOOP = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 600 && done_n == 0; i++) begin
            if (mode == 1 && !acted && q.size() == 1) begin
                WR_EN = 1'b1; WR_ADDR = 4'd1; WR_DAT = 4'd9; acted = 1'b1;
            end else if (mode == 2 && !acted && q.size() == 1) begin
                START = 1'b1; LEN = 4'd15; LOOP = 1'b1; acted = 1'b1;
            end
            tick();
            WR_EN = 1'b0; START = 1'b0;
        end
        LOOP = 1'b0;
        chk({tag, "_done_seen"}, done_n, 1);
        chk({tag, "_n_strobes"}, q.size(), n);
        for (int k = 0; k < n && k < q.size(); k++)
            chk($sformatf("%s_dat%0d", tag, k), int'(q[k]), int'(exp[k*4 +: 4]));
        for (int k = 1; k < q.size(); k++)
            chk($sformatf("%s_gap%0d", tag, k), qc[k] - qc[k-1], 8);
        if (q.size() > 0) begin
            d = done_cyc - qc[q.size()-1];
            chk({tag, "_done_lat"}, int'(d >= 1 && d <= 2), 1);
        end
        chk({tag, "_busy_end"}, int'(BUSY), 0);
        chk({tag, "_idx_end"}, int'(IDX_O), 0);
        tick(2);
        chk({tag, "_single_done"}, done_n, 1);
    endtask

    typedef struct {
        string       name;
        logic [63:0] tab;
        logic [3:0]  len;
        int          n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[4];
    int   n0;

    initial begin
        vecs[0] = '{"a5f0",   64'h0000_0000_0000_0F5A, 4'd3,  4,  64'h0000_0000_0000_0F5A};
        vecs[1] = '{"len0",   64'hFFFF_FFFF_FFFF_FFF7, 4'd0,  1,  64'h0000_0000_0000_0007};
        vecs[2] = '{"len15",  64'h0123_4567_89AB_CDEF, 4'd15, 16, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{"len2",   64'h0000_0000_0000_EC63, 4'd2,  3,  64'h0000_0000_0000_0C63};

        // Reset state
        tick(3);
        chk("rst_outs", int'({DAT_O, STB_O, BUSY, DONE, IDX_O}), 0);
        SYS_NRST = 1'b1;
        tick(4);
        chk("idle_busy", int'(BUSY), 0);

        // Table-driven single-shot runs
        foreach (vecs[i]) begin
            write_tab(vecs[i].tab);
            play(vecs[i].name, vecs[i].len, vecs[i].n, vecs[i].exp, 0);
        end

        // Looping 3,C then STOP
        write_tab(64'h0000_0000_0000_00C3);
        q.delete(); qc.delete(); done_n = 0;
        LEN = 4'd1; LOOP = 1'b1; START = 1'b1;
        tick();
        START = 1'b0; LOOP = 1'b0; LEN = 4'd0;
        for (int i = 0; i < 200 && q.size() < 6; i++) tick();
        chk("loop_n", int'(q.size() >= 6), 1);
        for (int k = 0; k < 6 && k < q.size(); k++)
            chk($sformatf("loop_dat%0d", k), int'(q[k]), (k % 2 == 0) ? 3 : 12);
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        n0 = q.size();
        tick();
        chk("stop_busy", int'(BUSY), 0);
        tick(40);
        chk("stop_no_stb", q.size(), n0);
        chk("stop_no_done", done_n, 0);
        chk("stop_dat_held", int'(DAT_O), int'(q[n0-1]));

        // Write during busy is ignored; replay shows old contents; IDLE write lands
        write_tab(64'h0000_0000_0000_4321);
        play("wr_busy", 4'd3, 4, 64'h0000_0000_0000_4321, 1);
        play("wr_replay", 4'd3, 4, 64'h0000_0000_0000_4321, 0);
        WR_EN = 1'b1; WR_ADDR = 4'd1; WR_DAT = 4'd9;
        tick();
        WR_EN = 1'b0;
        play("wr_idle", 4'd3, 4, 64'h0000_0000_0000_4391, 0);

        // START (with new LEN/LOOP) while busy: no restart, no effect
        play("start_busy", 4'd3, 4, 64'h0000_0000_0000_4391, 2);

        // START and STOP together: stays idle
        q.delete();
        START = 1'b1; STOP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0;
        tick(20);
        chk("startstop_busy", int'(BUSY), 0);
        chk("startstop_no_stb", q.size(), 0);

        // Reset mid-run, then the table must read back as zeros
        q.delete(); done_n = 0;
        LEN = 4'd1; LOOP = 1'b1; START = 1'b1;
        tick();
        START = 1'b0; LOOP = 1'b0;
        for (int i = 0; i < 100 && q.size() < 2; i++) tick();
        chk("pre_rst_stb", int'(q.size() >= 2), 1);
        SYS_NRST = 1'b0;
        #1;
        chk("midrst_outs", int'({DAT_O, STB_O, BUSY, DONE, IDX_O}), 0);
        n0 = q.size();
        tick(10);
        chk("midrst_no_stb", q.size(), n0);
        chk("midrst_no_done", done_n, 0);
        SYS_NRST = 1'b1;
        tick(4);
        play("rst_tab0", 4'd3, 4, 64'h0, 0);

        chk("stb_consecutive", consec, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
